inst_axi_rd_bridge: RTL
=======================

Name: inst_axi_rd_bridge

Overview:
- Converts the instruction-side SRAM-like fetch interface (req / addr_ok / data_ok) into AXI4 read address (AR) and read data (R) channel transactions.
- Sits directly upstream of the fetch stage. It supplies the fetch stage's inst_sram_addr_ok, inst_sram_data_ok and inst_sram_rdata, and drives the AXI master read port toward the interconnect.
- Single-beat reads only. Responses return in order. A bounded number of requests may be outstanding.

Parameters:
- MAX_OUTSTANDING, 2: maximum number of accepted requests whose data has not yet been returned; legal range 1-7.
- ARID_VAL, 0: constant value driven on arid; rid is ignored.

Ports:
- clk  input  1  clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- inst_sram_en  input  1  fetch request valid.
- inst_sram_size  input  2  0: 1 byte, 1: 2 bytes, 2: 4 bytes.
- inst_sram_addr  input  32  fetch byte address.
- inst_sram_addr_ok  output  1  request accepted this cycle.
- inst_sram_data_ok  output  1  fetch data valid this cycle.
- inst_sram_rdata  output  32  fetch data.
- arid  output  4  constant ARID_VAL.
- araddr  output  32  read address.
- arlen  output  8  constant 0.
- arsize  output  3  {1'b0, latched size}.
- arburst  output  2  constant 2'b01 (INCR).
- arvalid  output  1  AR valid.
- arready  input  1  AR ready.
- rid  input  4  ignored.
- rdata  input  32  read data.
- rresp  input  2  read response.
- rlast  input  1  last beat.
- rvalid  input  1  R valid.
- rready  output  1  R ready.

Behaviour:
- Reset values:
  - arvalid=0, araddr=0, arsize=0.
  - inst_sram_addr_ok=0, inst_sram_data_ok=0, inst_sram_rdata=0.
  - rready=0.
  - outstanding counter cnt=0.
  - AR FSM in AR_IDLE.
  - Reset clears all state regardless of any in-flight transaction. It must be applied together with the AXI slave reset.
- AR FSM states:
  - AR_IDLE to AR_SEND: on acceptance.
  - AR_SEND to AR_IDLE: when arvalid && arready.
- Acceptance (combinational):
  - inst_sram_addr_ok = inst_sram_en && state==AR_IDLE && cnt<MAX_OUTSTANDING && !reset.
  - On addr_ok, latch araddr<=inst_sram_addr and arsize<=inst_sram_size.
  - arvalid=1 from the next cycle until the arready handshake.
  - araddr and arsize are held stable while arvalid=1.
- Throughput:
  - Back-to-back requests: a new acceptance is possible in the cycle after the AR handshake.
  - Peak rate is one request per 2 cycles when arready is always 1.
- Counter cnt (width 3):
  - +1 on addr_ok.
  - -1 on an R handshake (rvalid && rready && rlast).
  - Both in the same cycle: unchanged.
  - Never wraps. A full counter blocks addr_ok.
- rready:
  - Registered; equals (cnt!=0) after reset.
  - rready=1 whenever any request is outstanding; the fetch stage buffers data itself.
  - A beat arriving with cnt==0 is not accepted (rready=0). No data_ok results.
- Data return:
  - Registered, 1-cycle latency. A beat handshaken in cycle t gives inst_sram_data_ok=1 and inst_sram_rdata=rdata in cycle t+1.
  - data_ok is a one-cycle pulse per beat.
  - rdata holds its last value when data_ok=0.
- Ordering: data_ok pulses occur in the same order as the corresponding addr_ok pulses. No request is ever dropped; the fetch stage discards unwanted data itself.
- inst_sram_en is sampled only when addr_ok could be asserted. Changing address/size while not accepted is legal.
- rresp is ignored unless INST_BRIDGE_RESP_ERR_EN is defined.

Optional Feature:
- Macro: INST_BRIDGE_RESP_ERR_EN.
- When defined:
  - Adds output port inst_sram_err (1 bit, reset 0), registered alongside data_ok.
  - inst_sram_err=1 with data_ok when rresp is SLVERR (2'b10) or DECERR (2'b11). inst_sram_rdata is then forced to 32'h0.
  - inst_sram_err=0 otherwise.
- When undefined: no port, and rresp has no effect.

Test Plan:
- Single fetch:
  - Stimulus: en=1, addr=0x1c000000, size=2; arready=1 the next cycle; R beat rdata=0x02800000, rresp=0 two cycles later.
  - Response: addr_ok for 1 cycle; arvalid for 1 cycle with araddr=0x1c000000, arsize=2, arlen=0, arburst=1; data_ok one cycle after the beat with rdata=0x02800000.
- Outstanding limit (MAX_OUTSTANDING=2):
  - Stimulus: en held at 1, arready=1, no R beats.
  - Response: exactly 2 addr_ok pulses, then addr_ok stays 0. One R beat re-enables exactly one further acceptance.
- AR backpressure:
  - Stimulus: arready=0 for 5 cycles after acceptance.
  - Response: arvalid=1 and araddr stable for all 5 cycles; addr_ok=0 throughout; AR handshake on cycle 6.
- Simultaneous events:
  - Stimulus: addr_ok and R handshake in the same cycle with cnt=1.
  - Response: cnt remains 1; data_ok next cycle.
- Reset mid-operation:
  - Stimulus: assert reset while arvalid=1 and cnt=2.
  - Response: next cycle arvalid=0, cnt=0, rready=0, data_ok=0; a fetch after reset behaves as in the single-fetch case.
- With INST_BRIDGE_RESP_ERR_EN:
  - Stimulus: beat with rresp=2'b10, rdata=0xdeadbeef.
  - Response: data_ok=1, inst_sram_err=1, inst_sram_rdata=0.

Source files
------------

// File: rtl/inst_axi_rd_bridge.sv
// inst_axi_rd_bridge: instruction fetch SRAM-like (req/addr_ok/data_ok) to AXI4
// read channel bridge. It issues single-beat reads, returns data in order and
// allows up to MAX_OUTSTANDING requests in flight.
//
// Optional feature macro: INST_BRIDGE_RESP_ERR_EN
//   When it is defined, the output inst_sram_err is added. It pulses with
//   data_ok on a SLVERR or DECERR response, and the returned data is zeroed.
//
// Ports:
//   clk, reset        : clock and synchronous active-high reset
//   inst_sram_*       : fetch-side request (en/size/addr) and response
//                       (addr_ok comb, data_ok/rdata registered)
//   ar*               : AXI read address channel (master)
//   r*                : AXI read data channel (master); rid is ignored
`timescale 1ns/1ps

module inst_axi_rd_bridge #(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [3:0]  ARID_VAL        = 4'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_sram_en,
    input  logic [1:0]  inst_sram_size,
    input  logic [31:0] inst_sram_addr,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,
`ifdef INST_BRIDGE_RESP_ERR_EN
    output logic        inst_sram_err,
`endif
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    localparam int unsigned CNT_W  = 3;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    typedef enum logic {
        AR_IDLE = 1'b0,
        AR_SEND = 1'b1
    } ar_state_e;

    ar_state_e          state_q, state_d;
    logic [ADDR_W-1:0]  araddr_q, araddr_d;
    logic [1:0]         arsize_q, arsize_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               rready_q, rready_d;
    logic               data_ok_q, data_ok_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               addr_ok;
    logic               r_hs;
`ifdef INST_BRIDGE_RESP_ERR_EN
    logic               err_q, err_d;
    logic               unused_rid;
    assign unused_rid = ^rid;
`else
    logic               unused_rid_rresp;
    assign unused_rid_rresp = ^{rid, rresp};
`endif

    // A beat completes only while something is outstanding (rready_q tracks cnt != 0)
    assign r_hs = rvalid && rready_q && rlast;

    // AR FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= AR_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // AR FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            AR_IDLE: if (addr_ok)            state_d = AR_SEND;
            AR_SEND: if (arvalid && arready) state_d = AR_IDLE;
            default:                         state_d = AR_IDLE;
        endcase
    end

    // AR FSM: outputs; acceptance is combinational so the fetch stage sees it in-cycle
    always_comb begin
        arvalid = 1'b0;
        addr_ok = 1'b0;
        case (state_q)
            AR_IDLE: addr_ok = inst_sram_en && (cnt_q < CNT_W'(MAX_OUTSTANDING)) && !reset;
            AR_SEND: arvalid = 1'b1;
            default: ;
        endcase
    end

    // Datapath next-state: AR payload latch, outstanding counter, response register
    always_comb begin
        araddr_d  = araddr_q;
        arsize_d  = arsize_q;
        cnt_d     = cnt_q;
        data_ok_d = r_hs;
        rdata_d   = rdata_q;

        if (addr_ok) begin
            araddr_d = inst_sram_addr;
            arsize_d = inst_sram_size;
        end

        // Accept and retire in the same cycle cancel; full counter blocks addr_ok,
        // and r_hs implies cnt_q != 0, so the counter never wraps.
        case ({addr_ok, r_hs})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase

        rready_d = (cnt_d != '0);

`ifdef INST_BRIDGE_RESP_ERR_EN
        err_d = 1'b0;
        if (r_hs) begin
            err_d   = rresp[1];
            rdata_d = rresp[1] ? '0 : rdata;
        end
`else
        if (r_hs) begin
            rdata_d = rdata;
        end
`endif
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            araddr_q  <= '0;
            arsize_q  <= '0;
            cnt_q     <= '0;
            rready_q  <= 1'b0;
            data_ok_q <= 1'b0;
            rdata_q   <= '0;
`ifdef INST_BRIDGE_RESP_ERR_EN
            err_q     <= 1'b0;
`endif
        end else begin
            araddr_q  <= araddr_d;
            arsize_q  <= arsize_d;
            cnt_q     <= cnt_d;
            rready_q  <= rready_d;
            data_ok_q <= data_ok_d;
            rdata_q   <= rdata_d;
`ifdef INST_BRIDGE_RESP_ERR_EN
            err_q     <= err_d;
`endif
        end
    end

    assign inst_sram_addr_ok = addr_ok;
    assign inst_sram_data_ok = data_ok_q;
    assign inst_sram_rdata   = rdata_q;
`ifdef INST_BRIDGE_RESP_ERR_EN
    assign inst_sram_err     = err_q;
`endif
    assign arid    = ARID_VAL;
    assign araddr  = araddr_q;
    assign arlen   = 8'd0;
    assign arsize  = {1'b0, arsize_q};
    assign arburst = 2'b01;
    assign rready  = rready_q;

endmodule
